// File: rtl/player_anim_if.sv
`default_nettype none
// ============================================================================
//  Module      : player_anim_if
//  Description : Game-logic <-> player animation controller bundle. Carries the
//                per-frame strobe, direction keys, life-cycle events and the
//                sprite selection / visibility outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface player_anim_if;
    logic       startOfFrame;
    logic [3:0] dirKeys;
    logic       playerHit;
    logic       respawnReq;
    logic [4:0] frameSel;
    logic       mirrorX;
    logic       spriteEnable;
    logic       playerAlive;
    logic       deathDone;

    // Game-logic side: produces events, consumes sprite controls
    modport master (
        output startOfFrame, dirKeys, playerHit, respawnReq,
        input  frameSel, mirrorX, spriteEnable, playerAlive, deathDone
    );

    // Animation controller side
    modport slave (
        input  startOfFrame, dirKeys, playerHit, respawnReq,
        output frameSel, mirrorX, spriteEnable, playerAlive, deathDone
    );
endinterface
`default_nettype wire

// File: rtl/player_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : player_anim_ctrl
//  Description : Player sprite sequencer. Owns the life-cycle FSM
//                (idle, walk, dying, dead, respawn blink) and picks the sprite
//                frame index, mirroring and visibility once per VGA frame.
//                Optional macro PLAYER_ANIM_MIRROR_EN: LEFT reuses the RIGHT
//                bank with mirrorX=1 instead of using its own bank 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_anim_ctrl #(
    parameter int FRAMES_PER_STEP = 8,
    parameter int WALK_FRAMES     = 4,
    parameter int DEATH_FRAMES    = 6,
    parameter int BLINK_FRAMES    = 120,
    parameter int BLINK_HALF      = 8
) (
    input  logic         clk,
    input  logic         resetN,
    player_anim_if.slave bus
);

    // Facing / bank codes: bank index doubles as frameSel[3:2]
    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [7:0] DIV_LAST   = 8'(FRAMES_PER_STEP - 1);
    localparam logic [1:0] STEP_LAST  = 2'(WALK_FRAMES - 1);
    localparam logic [3:0] DEATH_LAST = 4'(DEATH_FRAMES - 1);
    localparam logic [9:0] BLINK_LAST = 10'(BLINK_FRAMES - 1);
    localparam logic [7:0] HALF_LAST  = 8'(BLINK_HALF - 1);

`ifdef PLAYER_ANIM_MIRROR_EN
    localparam bit MIRROR_EN = 1'b1;
`else
    localparam bit MIRROR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WALK    = 3'd1,
        ST_DYING   = 3'd2,
        ST_DEAD    = 3'd3,
        ST_RESPAWN = 3'd4
    } state_t;

    state_t     state;
    logic [1:0] facing;
    logic [1:0] step;
    logic [7:0] div_cnt;
    logic [3:0] death_step;
    logic [9:0] blink_cnt;
    logic [7:0] half_cnt;
    logic       moving;

    logic [4:0] frame_sel;
    logic       mirror_x;
    logic       sprite_en;
    logic       alive;
    logic       death_done;

    logic       key_any;
    logic [1:0] key_dir;
    logic [1:0] walk_facing;
    logic [1:0] walk_step;
    logic [7:0] walk_div;

    // Walk frames live in banks of four; mirrored builds fold LEFT onto RIGHT
    function automatic logic [4:0] walk_frame(input logic [1:0] dir, input logic [1:0] stp);
        logic [1:0] bank;
        bank = (MIRROR_EN && (dir == DIR_LEFT)) ? DIR_RIGHT : dir;
        return {1'b0, bank, stp};
    endfunction

    function automatic logic walk_mirror(input logic [1:0] dir);
        return MIRROR_EN && (dir == DIR_LEFT);
    endfunction

    // Key decode and the walk-animation step shared by IDLE/WALK and RESPAWN
    always_comb begin
        key_any     = |bus.dirKeys;
        if (bus.dirKeys[3])      key_dir = DIR_UP;
        else if (bus.dirKeys[2]) key_dir = DIR_DOWN;
        else if (bus.dirKeys[1]) key_dir = DIR_LEFT;
        else                     key_dir = DIR_RIGHT;

        walk_facing = facing;
        walk_step   = step;
        walk_div    = div_cnt;
        if (!key_any) begin
            // Standing still: keep facing, restart the walk cycle
            walk_step = 2'd0;
            walk_div  = 8'd0;
        end else if (!moving || (key_dir != facing)) begin
            // Starting to walk or turning: fresh cycle in the new direction
            walk_facing = key_dir;
            walk_step   = 2'd0;
            walk_div    = 8'd0;
        end else if (div_cnt == DIV_LAST) begin
            walk_div  = 8'd0;
            walk_step = (step == STEP_LAST) ? 2'd0 : step + 2'd1;
        end else begin
            walk_div = div_cnt + 8'd1;
        end
    end

    // Life-cycle FSM with registered sprite controls
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_IDLE;
            facing     <= DIR_DOWN;
            step       <= 2'd0;
            div_cnt    <= 8'd0;
            death_step <= 4'd0;
            blink_cnt  <= 10'd0;
            half_cnt   <= 8'd0;
            moving     <= 1'b0;
            frame_sel  <= 5'd0;
            mirror_x   <= 1'b0;
            sprite_en  <= 1'b1;
            alive      <= 1'b1;
            death_done <= 1'b0;
        end else begin
            death_done <= 1'b0;
            case (state)
                ST_IDLE, ST_WALK: begin
                    if (bus.playerHit) begin
                        // Hit beats a coincident frame strobe; that frame's keys are dropped
                        state      <= ST_DYING;
                        step       <= 2'd0;
                        div_cnt    <= 8'd0;
                        death_step <= 4'd0;
                        moving     <= 1'b0;
                        frame_sel  <= 5'd16;
                        mirror_x   <= 1'b0;
                        alive      <= 1'b0;
                    end else if (bus.startOfFrame) begin
                        state     <= key_any ? ST_WALK : ST_IDLE;
                        facing    <= walk_facing;
                        step      <= walk_step;
                        div_cnt   <= walk_div;
                        moving    <= key_any;
                        frame_sel <= walk_frame(walk_facing, walk_step);
                        mirror_x  <= walk_mirror(walk_facing);
                    end
                end

                ST_DYING: begin
                    if (bus.startOfFrame) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= 8'd0;
                            if (death_step == DEATH_LAST) begin
                                // Last frame has been shown for a full step
                                state      <= ST_DEAD;
                                death_done <= 1'b1;
                                sprite_en  <= 1'b0;
                            end else begin
                                death_step <= death_step + 4'd1;
                                frame_sel  <= {1'b1, death_step + 4'd1};
                            end
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                end

                ST_DEAD: begin
                    if (bus.respawnReq) begin
                        state     <= ST_RESPAWN;
                        facing    <= DIR_DOWN;
                        step      <= 2'd0;
                        div_cnt   <= 8'd0;
                        moving    <= 1'b0;
                        blink_cnt <= 10'd0;
                        half_cnt  <= 8'd0;
                        frame_sel <= walk_frame(DIR_DOWN, 2'd0);
                        mirror_x  <= 1'b0;
                        sprite_en <= 1'b1;
                        alive     <= 1'b1;
                    end
                end

                ST_RESPAWN: begin
                    if (bus.startOfFrame) begin
                        if (blink_cnt == BLINK_LAST) begin
                            // Invulnerability over: back to a steady, standing sprite
                            state     <= ST_IDLE;
                            step      <= 2'd0;
                            div_cnt   <= 8'd0;
                            moving    <= 1'b0;
                            blink_cnt <= 10'd0;
                            half_cnt  <= 8'd0;
                            sprite_en <= 1'b1;
                            frame_sel <= walk_frame(facing, 2'd0);
                            mirror_x  <= walk_mirror(facing);
                        end else begin
                            blink_cnt <= blink_cnt + 10'd1;
                            if (half_cnt == HALF_LAST) begin
                                half_cnt  <= 8'd0;
                                sprite_en <= ~sprite_en;
                            end else begin
                                half_cnt <= half_cnt + 8'd1;
                            end
                            facing    <= walk_facing;
                            step      <= walk_step;
                            div_cnt   <= walk_div;
                            moving    <= key_any;
                            frame_sel <= walk_frame(walk_facing, walk_step);
                            mirror_x  <= walk_mirror(walk_facing);
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.frameSel     = frame_sel;
    assign bus.mirrorX      = mirror_x;
    assign bus.spriteEnable = sprite_en;
    assign bus.playerAlive  = alive;
    assign bus.deathDone    = death_done;

endmodule
`default_nettype wire

// File: tb/tb_player_anim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_anim_ctrl
//  Description : Directed self-checking bench for player_anim_ctrl with
//                default parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_anim_ctrl;

    logic clk = 1'b0;
    logic resetN;
    int   checks = 0;
    int   errors = 0;
    int   dd_count = 0;

`ifdef PLAYER_ANIM_MIRROR_EN
    localparam logic [4:0] EXP_LEFT_FRAME = 5'd8;
    localparam logic       EXP_LEFT_MIR   = 1'b1;
`else
    localparam logic [4:0] EXP_LEFT_FRAME = 5'd12;
    localparam logic       EXP_LEFT_MIR   = 1'b0;
`endif

    player_anim_if bus();

    player_anim_ctrl dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Count deathDone pulses, sampled shortly after each rising edge
    always @(posedge clk) begin
        #2;
        if (bus.deathDone === 1'b1) dd_count++;
    end

    // One startOfFrame pulse per call, with idle cycles around it
    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.startOfFrame = 1'b1;
            @(negedge clk) bus.startOfFrame = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic hit_pulse();
        @(negedge clk) bus.playerHit = 1'b1;
        @(negedge clk) bus.playerHit = 1'b0;
    endtask

    task automatic respawn_pulse();
        @(negedge clk) bus.respawnReq = 1'b1;
        @(negedge clk) bus.respawnReq = 1'b0;
    endtask

    task automatic test_reset();
        resetN           = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.dirKeys      = 4'd0;
        bus.playerHit    = 1'b0;
        bus.respawnReq   = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.frameSel !== 5'd0) begin errors++; $display("FAIL reset_frame: frameSel=%0d expected 0", bus.frameSel); end
        checks++; if (bus.mirrorX !== 1'b0) begin errors++; $display("FAIL reset_mirror: mirrorX=%b expected 0", bus.mirrorX); end
        checks++; if (bus.spriteEnable !== 1'b1) begin errors++; $display("FAIL reset_sprite: spriteEnable=%b expected 1", bus.spriteEnable); end
        checks++; if (bus.playerAlive !== 1'b1) begin errors++; $display("FAIL reset_alive: playerAlive=%b expected 1", bus.playerAlive); end
        checks++; if (bus.deathDone !== 1'b0) begin errors++; $display("FAIL reset_done: deathDone=%b expected 0", bus.deathDone); end
        @(negedge clk) resetN = 1'b1;
    endtask

    task automatic test_idle();
        for (int f = 0; f < 20; f++) begin
            pulses(1);
            checks++; if (bus.frameSel !== 5'd0) begin errors++; $display("FAIL idle_frame[%0d]: frameSel=%0d expected 0", f, bus.frameSel); end
        end
        checks++; if (bus.spriteEnable !== 1'b1) begin errors++; $display("FAIL idle_sprite: spriteEnable=%b expected 1", bus.spriteEnable); end
        checks++; if (bus.playerAlive !== 1'b1) begin errors++; $display("FAIL idle_alive: playerAlive=%b expected 1", bus.playerAlive); end
        checks++; if (dd_count !== 0) begin errors++; $display("FAIL idle_done: deathDone pulses=%0d expected 0", dd_count); end
    endtask

    task automatic test_walk();
        bus.dirKeys = 4'b0001;
        pulses(1);
        checks++; if (bus.frameSel !== 5'd8) begin errors++; $display("FAIL walk_start: frameSel=%0d expected 8", bus.frameSel); end
        checks++; if (bus.mirrorX !== 1'b0) begin errors++; $display("FAIL walk_mirror: mirrorX=%b expected 0", bus.mirrorX); end
        pulses(7);
        checks++; if (bus.frameSel !== 5'd8) begin errors++; $display("FAIL walk_hold7: frameSel=%0d expected 8", bus.frameSel); end
        pulses(1);
        checks++; if (bus.frameSel !== 5'd9) begin errors++; $display("FAIL walk_step1: frameSel=%0d expected 9", bus.frameSel); end
        pulses(8);
        checks++; if (bus.frameSel !== 5'd10) begin errors++; $display("FAIL walk_step2: frameSel=%0d expected 10", bus.frameSel); end
        pulses(8);
        checks++; if (bus.frameSel !== 5'd11) begin errors++; $display("FAIL walk_step3: frameSel=%0d expected 11", bus.frameSel); end
        pulses(8);
        checks++; if (bus.frameSel !== 5'd8) begin errors++; $display("FAIL walk_wrap: frameSel=%0d expected 8", bus.frameSel); end
        // Key change without a frame strobe must not move the sprite
        @(negedge clk) bus.dirKeys = 4'b0010;
        repeat (3) @(negedge clk);
        checks++; if (bus.frameSel !== 5'd8) begin errors++; $display("FAIL walk_midframe: frameSel=%0d expected 8", bus.frameSel); end
        bus.dirKeys = 4'b0000;
        pulses(1);
        checks++; if (bus.frameSel !== 5'd8) begin errors++; $display("FAIL walk_release: frameSel=%0d expected 8", bus.frameSel); end
    endtask

    task automatic test_priority();
        bus.dirKeys = 4'b1010;
        pulses(1);
        checks++; if (bus.frameSel !== 5'd4) begin errors++; $display("FAIL prio_up_left: frameSel=%0d expected 4", bus.frameSel); end
        bus.dirKeys = 4'b0010;
        pulses(1);
        checks++; if (bus.frameSel !== EXP_LEFT_FRAME) begin errors++; $display("FAIL left_frame: frameSel=%0d expected %0d", bus.frameSel, EXP_LEFT_FRAME); end
        checks++; if (bus.mirrorX !== EXP_LEFT_MIR) begin errors++; $display("FAIL left_mirror: mirrorX=%b expected %b", bus.mirrorX, EXP_LEFT_MIR); end
        bus.dirKeys = 4'b0101;
        pulses(1);
        checks++; if (bus.frameSel !== 5'd0) begin errors++; $display("FAIL prio_down_right: frameSel=%0d expected 0", bus.frameSel); end
        checks++; if (bus.mirrorX !== 1'b0) begin errors++; $display("FAIL down_mirror: mirrorX=%b expected 0", bus.mirrorX); end
    endtask

    task automatic test_death();
        bus.dirKeys = 4'b0001;
        pulses(1);
        checks++; if (bus.frameSel !== 5'd8) begin errors++; $display("FAIL death_prewalk: frameSel=%0d expected 8", bus.frameSel); end
        @(negedge clk) begin bus.startOfFrame = 1'b1; bus.playerHit = 1'b1; end
        @(negedge clk) begin bus.startOfFrame = 1'b0; bus.playerHit = 1'b0; end
        checks++; if (bus.frameSel !== 5'd16) begin errors++; $display("FAIL death_enter: frameSel=%0d expected 16", bus.frameSel); end
        checks++; if (bus.playerAlive !== 1'b0) begin errors++; $display("FAIL death_alive: playerAlive=%b expected 0", bus.playerAlive); end
        bus.dirKeys = 4'b0000;
        pulses(20);
        checks++; if (bus.frameSel !== 5'd18) begin errors++; $display("FAIL death_20: frameSel=%0d expected 18", bus.frameSel); end
        hit_pulse();
        checks++; if (bus.frameSel !== 5'd18) begin errors++; $display("FAIL death_rehit: frameSel=%0d expected 18", bus.frameSel); end
        pulses(10);
        respawn_pulse();
        checks++; if (bus.frameSel !== 5'd19) begin errors++; $display("FAIL death_respawn_ign: frameSel=%0d expected 19", bus.frameSel); end
        checks++; if (bus.playerAlive !== 1'b0) begin errors++; $display("FAIL death_respawn_alive: playerAlive=%b expected 0", bus.playerAlive); end
        pulses(10);
        checks++; if (bus.frameSel !== 5'd21) begin errors++; $display("FAIL death_40: frameSel=%0d expected 21", bus.frameSel); end
        pulses(7);
        checks++; if (dd_count !== 0) begin errors++; $display("FAIL death_47_done: deathDone pulses=%0d expected 0", dd_count); end
        checks++; if (bus.spriteEnable !== 1'b1) begin errors++; $display("FAIL death_47_sprite: spriteEnable=%b expected 1", bus.spriteEnable); end
        pulses(1);
        checks++; if (dd_count !== 1) begin errors++; $display("FAIL death_48_done: deathDone pulses=%0d expected 1", dd_count); end
        checks++; if (bus.spriteEnable !== 1'b0) begin errors++; $display("FAIL death_48_sprite: spriteEnable=%b expected 0", bus.spriteEnable); end
        pulses(3);
        checks++; if (bus.frameSel !== 5'd21) begin errors++; $display("FAIL dead_frame: frameSel=%0d expected 21", bus.frameSel); end
        checks++; if (bus.playerAlive !== 1'b0) begin errors++; $display("FAIL dead_alive: playerAlive=%b expected 0", bus.playerAlive); end
        checks++; if (dd_count !== 1) begin errors++; $display("FAIL dead_done_once: deathDone pulses=%0d expected 1", dd_count); end
    endtask

    task automatic test_respawn();
        respawn_pulse();
        checks++; if (bus.spriteEnable !== 1'b1) begin errors++; $display("FAIL resp_sprite0: spriteEnable=%b expected 1", bus.spriteEnable); end
        checks++; if (bus.playerAlive !== 1'b1) begin errors++; $display("FAIL resp_alive: playerAlive=%b expected 1", bus.playerAlive); end
        checks++; if (bus.frameSel !== 5'd0) begin errors++; $display("FAIL resp_frame: frameSel=%0d expected 0", bus.frameSel); end
        pulses(7);
        checks++; if (bus.spriteEnable !== 1'b1) begin errors++; $display("FAIL blink_7: spriteEnable=%b expected 1", bus.spriteEnable); end
        pulses(1);
        checks++; if (bus.spriteEnable !== 1'b0) begin errors++; $display("FAIL blink_8: spriteEnable=%b expected 0", bus.spriteEnable); end
        pulses(7);
        checks++; if (bus.spriteEnable !== 1'b0) begin errors++; $display("FAIL blink_15: spriteEnable=%b expected 0", bus.spriteEnable); end
        pulses(1);
        checks++; if (bus.spriteEnable !== 1'b1) begin errors++; $display("FAIL blink_16: spriteEnable=%b expected 1", bus.spriteEnable); end
        hit_pulse();
        checks++; if (bus.playerAlive !== 1'b1) begin errors++; $display("FAIL blink_hit_alive: playerAlive=%b expected 1", bus.playerAlive); end
        checks++; if (bus.frameSel !== 5'd0) begin errors++; $display("FAIL blink_hit_frame: frameSel=%0d expected 0", bus.frameSel); end
        bus.dirKeys = 4'b0001;
        pulses(1);
        checks++; if (bus.frameSel !== 5'd8) begin errors++; $display("FAIL blink_walk: frameSel=%0d expected 8", bus.frameSel); end
        bus.dirKeys = 4'b0000;
        pulses(1);
        checks++; if (bus.frameSel !== 5'd8) begin errors++; $display("FAIL blink_stop: frameSel=%0d expected 8", bus.frameSel); end
        pulses(93);
        checks++; if (bus.spriteEnable !== 1'b0) begin errors++; $display("FAIL blink_111: spriteEnable=%b expected 0", bus.spriteEnable); end
        pulses(8);
        checks++; if (bus.spriteEnable !== 1'b1) begin errors++; $display("FAIL blink_119: spriteEnable=%b expected 1", bus.spriteEnable); end
        pulses(1);
        checks++; if (bus.spriteEnable !== 1'b1) begin errors++; $display("FAIL blink_end: spriteEnable=%b expected 1", bus.spriteEnable); end
        checks++; if (bus.frameSel !== 5'd8) begin errors++; $display("FAIL blink_end_frame: frameSel=%0d expected 8", bus.frameSel); end
        pulses(8);
        checks++; if (bus.spriteEnable !== 1'b1) begin errors++; $display("FAIL post_blink: spriteEnable=%b expected 1", bus.spriteEnable); end
        respawn_pulse();
        pulses(8);
        checks++; if (bus.spriteEnable !== 1'b1) begin errors++; $display("FAIL idle_respawn_ign: spriteEnable=%b expected 1", bus.spriteEnable); end
        checks++; if (bus.frameSel !== 5'd8) begin errors++; $display("FAIL idle_respawn_frame: frameSel=%0d expected 8", bus.frameSel); end
    endtask

    task automatic test_async_reset();
        hit_pulse();
        checks++; if (bus.frameSel !== 5'd16) begin errors++; $display("FAIL ar_dying: frameSel=%0d expected 16", bus.frameSel); end
        pulses(16);
        checks++; if (bus.frameSel !== 5'd18) begin errors++; $display("FAIL ar_pre: frameSel=%0d expected 18", bus.frameSel); end
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        checks++; if (bus.frameSel !== 5'd0) begin errors++; $display("FAIL ar_frame: frameSel=%0d expected 0", bus.frameSel); end
        checks++; if (bus.spriteEnable !== 1'b1) begin errors++; $display("FAIL ar_sprite: spriteEnable=%b expected 1", bus.spriteEnable); end
        checks++; if (bus.playerAlive !== 1'b1) begin errors++; $display("FAIL ar_alive: playerAlive=%b expected 1", bus.playerAlive); end
        @(negedge clk) resetN = 1'b1;
        pulses(1);
        checks++; if (bus.frameSel !== 5'd0) begin errors++; $display("FAIL ar_after: frameSel=%0d expected 0", bus.frameSel); end
        hit_pulse();
        checks++; if (bus.frameSel !== 5'd16) begin errors++; $display("FAIL ar_idle_hit: frameSel=%0d expected 16", bus.frameSel); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle();
        test_walk();
        test_priority();
        test_death();
        test_respawn();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_anim_ctrl.md
Name: player_anim_ctrl

Overview:
- Sequences the player sprite bitmap: picks the animation frame index, horizontal mirroring and sprite visibility once per VGA frame.
- Driven by direction keys, hit and respawn events.
- Sits between game logic (keys, collision, lives) and the player bitmap / drawing-request mux.
- Owns the player life-cycle state machine: idle, walk, death animation, dead, respawn blink.

Parameters:
- FRAMES_PER_STEP, 8, VGA frames per animation step (1..255)
- WALK_FRAMES, 4, walk frames per direction bank (1..4)
- DEATH_FRAMES, 6, death animation frames (1..16)
- BLINK_FRAMES, 120, respawn invulnerability length in VGA frames (1..1023)
- BLINK_HALF, 8, VGA frames per blink half-period (1..255)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clk pulse per VGA frame
- dirKeys  in  4  {up,down,left,right}, level, active-high
- playerHit  in  1  one-clk pulse, player touched blast/enemy
- respawnReq  in  1  one-clk pulse from game control
- frameSel  out  5  sprite index to bitmap ROM
- mirrorX  out  1  bitmap reads columns reversed
- spriteEnable  out  1  gates the bitmap drawingRequest
- playerAlive  out  1  player alive (IDLE/WALK/RESPAWN)
- deathDone  out  1  one-clk pulse when death animation ends

Behaviour:
- Reset is asynchronous and active-low, clock is clk. Reset values: state IDLE, facing DOWN, step 0, all counters 0. frameSel=0, mirrorX=0, spriteEnable=1, playerAlive=1, deathDone=0.
- All outputs are registered.
- Banks: DOWN=0, UP=1, RIGHT=2, LEFT=3. Walk frameSel = bank*4 + step. Death frameSel = 16 + deathStep.
- Keys are sampled only on startOfFrame, so the sprite never changes mid-frame. Key priority: up > down > left > right. With no key pressed, facing is held and step resets to 0.
- States:
  - IDLE: on a startOfFrame with a key pressed → WALK. Facing is updated, step 0, divider cleared.
  - WALK: each startOfFrame increments the divider. When the divider reaches FRAMES_PER_STEP-1 it clears and step advances, wrapping WALK_FRAMES-1 → 0. A direction change resets step and divider. No key → IDLE with step 0.
  - DYING: entered from IDLE/WALK on playerHit, in the next cycle. frameSel=16, playerAlive=0. deathStep advances every FRAMES_PER_STEP frames. The last frame is held FRAMES_PER_STEP frames, then the block pulses deathDone for one cycle and goes to DEAD.
  - DEAD: spriteEnable=0, playerAlive=0, frameSel frozen at the last death frame. respawnReq → RESPAWN.
  - RESPAWN: facing DOWN, step 0, playerAlive=1. Walk animation runs exactly as in WALK/IDLE. spriteEnable=1 for BLINK_HALF frames, then 0 for BLINK_HALF frames, repeating. After BLINK_FRAMES frames → IDLE with spriteEnable=1.
- Event priority and ignored events:
  - playerHit is ignored in DYING, DEAD and RESPAWN.
  - respawnReq is ignored outside DEAD.
  - If playerHit and startOfFrame arrive in the same cycle, the hit wins: DYING is entered with all counters cleared and keys for that frame ignored.
- Reset asserted in any state returns all outputs to reset values immediately, without waiting for a clk edge.

Optional Feature:
- Macro: PLAYER_ANIM_MIRROR_EN.
- Defined: LEFT reuses the RIGHT bank (frameSel base 8) with mirrorX=1. Bank 3 indices are unused.
- Undefined: LEFT uses bank 3 (frameSel base 12). mirrorX is tied to 0.

Test Plan (default parameters):
- Reset, no keys for 20 frames → frameSel=0 constant, spriteEnable=1, playerAlive=1, deathDone never asserted.
- Hold right → frameSel=8 after first startOfFrame. Then 9 after 8 more pulses, then 10 and 11. Back to 8 after 32 pulses. Release → frameSel=8 (step 0).
- Hold left + up together → up wins, frameSel=4. Left alone, macro on → frameSel=8, mirrorX=1. Macro off → frameSel=12, mirrorX=0.
- playerHit during WALK, same cycle as startOfFrame → next cycle frameSel=16, playerAlive=0. frameSel=21 after 40 pulses. deathDone pulses once after 48 pulses, then spriteEnable=0. A second playerHit mid-death has no effect.
- respawnReq in DEAD → spriteEnable 1 for 8 frames, 0 for 8, repeating. Steady 1 and state IDLE after 120 frames. playerHit during blink is ignored. respawnReq in IDLE is ignored.
- resetN low mid-DYING (frameSel=18) → outputs at reset values before the next clk edge. After release, state is IDLE and frameSel=0.
